// File: rtl/control_unit_fsm_pkg.sv
// ---------------------------------------------------------------------------
// control_unit_fsm_pkg
//   Shared definitions for the cs147sec05 multi-cycle control unit:
//   - FSM state encoding (visible on the STATE debug port)
//   - opcode / funct field values of the instruction set
//   - ALU operation codes driven on CTRL[25:21]
//   - bit positions inside the 32-bit CTRL word
//   - classify(): maps {opcode, funct} to an instruction class
//   - alu_op_of(): ALU operation requested by each instruction class
// ---------------------------------------------------------------------------
package control_unit_fsm_pkg;

    localparam int CTRL_W = 32;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Primary opcodes (instruction bits 31:26)
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MULI  = 6'h1d;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;

    // R-type funct codes (instruction bits 5:0)
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_MUL = 6'h2c;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_JR  = 6'h08;

    // ALU operation codes
    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_MUL = 5'd3;
    localparam logic [4:0] ALU_SRL = 5'd4;
    localparam logic [4:0] ALU_SLL = 5'd5;
    localparam logic [4:0] ALU_AND = 5'd6;
    localparam logic [4:0] ALU_OR  = 5'd7;
    localparam logic [4:0] ALU_NOR = 5'd8;
    localparam logic [4:0] ALU_SLT = 5'd9;

    // CTRL bit positions
    localparam int C_PC_LOAD   = 0;
    localparam int C_PC_SEL_1  = 1;   // 1: PC+1, 0: R[rs]
    localparam int C_PC_SEL_2  = 2;   // 1: branch target
    localparam int C_PC_SEL_3  = 3;   // 0: jump address
    localparam int C_MEM_R     = 4;
    localparam int C_MEM_W     = 5;
    localparam int C_R1_SEL_1  = 6;   // 1: rs, 0: R0
    localparam int C_REG_R     = 7;
    localparam int C_REG_W     = 8;
    localparam int C_WA_SEL_1  = 9;   // 1: rt, 0: rd
    localparam int C_WA_SEL_2  = 10;  // 1: R31, 0: R0
    localparam int C_WA_SEL_3  = 11;  // 1: rt/rd path
    localparam int C_WD_SEL_1  = 12;  // 1: memory data, 0: ALU result
    localparam int C_WD_SEL_2  = 13;  // 1: lui immediate
    localparam int C_WD_SEL_3  = 14;  // 0: PC+1
    localparam int C_SP_LOAD   = 15;
    localparam int C_OP1_SEL_1 = 16;  // 1: SP
    localparam int C_OP2_SEL_1 = 17;  // 1: shamt, 0: constant 1
    localparam int C_OP2_SEL_2 = 18;  // 1: sign-extended imm, 0: zero-extended
    localparam int C_OP2_SEL_3 = 19;  // 1: op2_sel_1 path, 0: immediate path
    localparam int C_OP2_SEL_4 = 20;  // 1: R[rt]
    localparam int C_ALU_LO    = 21;
    localparam int C_ALU_HI    = 25;
    localparam int C_MA_SEL_1  = 26;  // 1: SP
    localparam int C_DMEM_R    = 27;
    localparam int C_DMEM_W    = 28;
    localparam int C_MD_SEL_1  = 29;  // 1: R1 read port (push stores R0)
    localparam int C_IR_LOAD   = 30;
    localparam int C_MA_SEL_2  = 31;  // 1: PC

    typedef enum logic [4:0] {
        I_ADD, I_SUB, I_MUL, I_AND, I_OR, I_NOR, I_SLT, I_SLL, I_SRL, I_JR,
        I_ADDI, I_MULI, I_ANDI, I_ORI, I_LUI, I_SLTI,
        I_BEQ, I_BNE, I_LW, I_SW,
        I_JMP, I_JAL, I_PUSH, I_POP,
        I_ILLEGAL
    } instr_t;

    function automatic instr_t classify(input logic [5:0] op, input logic [5:0] fn);
        instr_t c;
        c = I_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  c = I_ADD;
                    FN_SUB:  c = I_SUB;
                    FN_MUL:  c = I_MUL;
                    FN_SRL:  c = I_SRL;
                    FN_SLL:  c = I_SLL;
                    FN_AND:  c = I_AND;
                    FN_OR:   c = I_OR;
                    FN_NOR:  c = I_NOR;
                    FN_SLT:  c = I_SLT;
                    FN_JR:   c = I_JR;
                    default: c = I_ILLEGAL;
                endcase
            end
            OP_ADDI: c = I_ADDI;
            OP_MULI: c = I_MULI;
            OP_ANDI: c = I_ANDI;
            OP_ORI:  c = I_ORI;
            OP_LUI:  c = I_LUI;
            OP_SLTI: c = I_SLTI;
            OP_BEQ:  c = I_BEQ;
            OP_BNE:  c = I_BNE;
            OP_LW:   c = I_LW;
            OP_SW:   c = I_SW;
            OP_JMP:  c = I_JMP;
            OP_JAL:  c = I_JAL;
            OP_PUSH: c = I_PUSH;
            OP_POP:  c = I_POP;
            default: c = I_ILLEGAL;
        endcase
        return c;
    endfunction

    // lw/sw/pop compute addresses with add; push decrements SP and
    // beq/bne compare by subtraction.
    function automatic logic [4:0] alu_op_of(input instr_t c);
        logic [4:0] a;
        a = ALU_NOP;
        case (c)
            I_ADD, I_ADDI, I_LW, I_SW, I_POP:  a = ALU_ADD;
            I_SUB, I_BEQ, I_BNE, I_PUSH:       a = ALU_SUB;
            I_MUL, I_MULI:                     a = ALU_MUL;
            I_SRL:                             a = ALU_SRL;
            I_SLL:                             a = ALU_SLL;
            I_AND, I_ANDI:                     a = ALU_AND;
            I_OR, I_ORI:                       a = ALU_OR;
            I_NOR:                             a = ALU_NOR;
            I_SLT, I_SLTI:                     a = ALU_SLT;
            default:                           a = ALU_NOP;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/control_unit_fsm_ctrl_decode.sv
// ---------------------------------------------------------------------------
// control_unit_fsm_ctrl_decode
//   Pure combinational output decoder of the control unit.
//   Ports:
//     state     in   state_t  current FSM state
//     ir        in   32       latched instruction
//     zflag     in   1        latched ALU zero flag
//     ctrl      out  32       data-path control word
//     mem_read  out  1        memory read strobe
//     mem_write out  1        memory write strobe
//   Only registered values feed this block, so the control word never
//   depends combinationally on INSTRUCTION or ZERO.
// ---------------------------------------------------------------------------
module control_unit_fsm_ctrl_decode
    import control_unit_fsm_pkg::*;
(
    input  state_t              state,
    input  logic [31:0]         ir,
    input  logic                zflag,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                mem_read,
    output logic                mem_write
);

    instr_t cls;
    logic   unused_ir_fields;

    assign cls = classify(ir[31:26], ir[5:0]);
    // Register/immediate fields are consumed by the data path, not here.
    assign unused_ir_fields = ^ir[25:6];

    always_comb begin
        ctrl      = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state)
            ST_FETCH: begin
                ctrl[C_MA_SEL_2] = 1'b1;
                ctrl[C_IR_LOAD]  = 1'b1;
                ctrl[C_MEM_R]    = 1'b1;
                mem_read         = 1'b1;
            end
            ST_DECODE: begin
                ctrl[C_REG_R]    = 1'b1;
                // push stores R0, so the first read port selects R0
                ctrl[C_R1_SEL_1] = (cls != I_PUSH);
            end
            ST_EXE: begin
                ctrl[C_ALU_HI:C_ALU_LO] = alu_op_of(cls);
                case (cls)
                    I_ADD, I_SUB, I_MUL, I_AND, I_OR, I_NOR, I_SLT,
                    I_BEQ, I_BNE: ctrl[C_OP2_SEL_4] = 1'b1;
                    I_SLL, I_SRL: begin
                        ctrl[C_OP2_SEL_3] = 1'b1;
                        ctrl[C_OP2_SEL_1] = 1'b1;
                    end
                    I_ADDI, I_MULI, I_SLTI, I_LW, I_SW:
                                  ctrl[C_OP2_SEL_2] = 1'b1;
                    // SP +/- constant 1
                    I_PUSH, I_POP: begin
                        ctrl[C_OP1_SEL_1] = 1'b1;
                        ctrl[C_OP2_SEL_3] = 1'b1;
                    end
                    // andi/ori use the zero-extended immediate: all selects 0
                    default: ;
                endcase
            end
            ST_MEM: begin
                case (cls)
                    I_LW: begin
                        ctrl[C_DMEM_R] = 1'b1;
                        mem_read       = 1'b1;
                    end
                    I_POP: begin
                        ctrl[C_DMEM_R]   = 1'b1;
                        ctrl[C_MA_SEL_1] = 1'b1;
                        mem_read         = 1'b1;
                    end
                    I_SW: begin
                        ctrl[C_DMEM_W] = 1'b1;
                        mem_write      = 1'b1;
                    end
                    I_PUSH: begin
                        ctrl[C_DMEM_W]   = 1'b1;
                        ctrl[C_MA_SEL_1] = 1'b1;
                        ctrl[C_MD_SEL_1] = 1'b1;
                        mem_write        = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                ctrl[C_PC_LOAD]  = 1'b1;
                ctrl[C_PC_SEL_1] = (cls != I_JR);
                ctrl[C_PC_SEL_3] = !(cls == I_JMP || cls == I_JAL);
                ctrl[C_PC_SEL_2] = (cls == I_BEQ) ? zflag :
                                   (cls == I_BNE) ? ~zflag : 1'b0;
                case (cls)
                    I_ADD, I_SUB, I_MUL, I_AND, I_OR, I_NOR, I_SLT,
                    I_SLL, I_SRL: begin
                        ctrl[C_REG_W]    = 1'b1;
                        ctrl[C_WA_SEL_3] = 1'b1;
                        ctrl[C_WD_SEL_3] = 1'b1;
                    end
                    I_ADDI, I_MULI, I_ANDI, I_ORI, I_SLTI: begin
                        ctrl[C_REG_W]    = 1'b1;
                        ctrl[C_WA_SEL_3] = 1'b1;
                        ctrl[C_WA_SEL_1] = 1'b1;
                        ctrl[C_WD_SEL_3] = 1'b1;
                    end
                    I_LW: begin
                        ctrl[C_REG_W]    = 1'b1;
                        ctrl[C_WA_SEL_3] = 1'b1;
                        ctrl[C_WA_SEL_1] = 1'b1;
                        ctrl[C_WD_SEL_3] = 1'b1;
                        ctrl[C_WD_SEL_1] = 1'b1;
                    end
                    I_LUI: begin
                        ctrl[C_REG_W]    = 1'b1;
                        ctrl[C_WA_SEL_3] = 1'b1;
                        ctrl[C_WA_SEL_1] = 1'b1;
                        ctrl[C_WD_SEL_3] = 1'b1;
                        ctrl[C_WD_SEL_2] = 1'b1;
                    end
                    // pop writes R0 (wa_sel_3=0, wa_sel_2=0) from memory
                    I_POP: begin
                        ctrl[C_REG_W]    = 1'b1;
                        ctrl[C_WD_SEL_3] = 1'b1;
                        ctrl[C_WD_SEL_1] = 1'b1;
                        ctrl[C_SP_LOAD]  = 1'b1;
                    end
                    I_PUSH: ctrl[C_SP_LOAD] = 1'b1;
                    // jal links PC+1 into R31
                    I_JAL: begin
                        ctrl[C_REG_W]    = 1'b1;
                        ctrl[C_WA_SEL_2] = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;  // HALT: everything deasserted
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// ---------------------------------------------------------------------------
// control_unit_fsm
//   Multi-cycle control unit: sequences each instruction through
//   FETCH -> DECODE -> EXE -> MEM -> WB (one instruction per 5 clocks).
//   Parameter:
//     ILLEGAL_HALT  1: unknown encoding parks the FSM in HALT until RST
//                   0: unknown encoding runs as a NOP (PC+1 only)
//   Ports:
//     CLK          in   1   clock
//     RST          in   1   synchronous active-high reset
//     INSTRUCTION  in   32  instruction word, sampled leaving FETCH
//     ZERO         in   1   ALU zero flag, sampled leaving EXE
//     CTRL         out  32  data-path control word
//     MEM_READ     out  1   memory read strobe
//     MEM_WRITE    out  1   memory write strobe
//     STATE        out  3   current state (debug)
//     HALTED       out  1   high while in HALT
// ---------------------------------------------------------------------------
module control_unit_fsm
    import control_unit_fsm_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         INSTRUCTION,
    input  logic                ZERO,
    output logic [CTRL_W-1:0]   CTRL,
    output logic                MEM_READ,
    output logic                MEM_WRITE,
    output logic [2:0]          STATE,
    output logic                HALTED
);

    state_t      state;
    logic [31:0] ir;
    logic        zflag;

    // Reset returns to FETCH from any state, so an instruction caught
    // mid-flight never reaches WB and issues no writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_FETCH;
            ir    <= '0;
            zflag <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir    <= INSTRUCTION;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (ILLEGAL_HALT && classify(ir[31:26], ir[5:0]) == I_ILLEGAL)
                        state <= ST_HALT;
                    else
                        state <= ST_EXE;
                end
                ST_EXE: begin
                    zflag <= ZERO;
                    state <= ST_MEM;
                end
                ST_MEM:  state <= ST_WB;
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                // unused encodings are treated as a fault
                default: state <= ST_HALT;
            endcase
        end
    end

    control_unit_fsm_ctrl_decode u_decode (
        .state     (state),
        .ir        (ir),
        .zflag     (zflag),
        .ctrl      (CTRL),
        .mem_read  (MEM_READ),
        .mem_write (MEM_WRITE)
    );

    assign STATE  = state;
    assign HALTED = (state == ST_HALT);

endmodule

// File: tb/tb_control_unit_fsm.sv
`timescale 1ns/1ps
module tb_control_unit_fsm;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] INSTRUCTION = '0;
    logic        ZERO = 1'b0;

    logic [31:0] ctrl_h, ctrl_n;
    logic        mr_h, mw_h, hl_h, mr_n, mw_n, hl_n;
    logic [2:0]  st_h, st_n;

    control_unit_fsm #(.ILLEGAL_HALT(1'b1)) dut_h (
        .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
        .CTRL(ctrl_h), .MEM_READ(mr_h), .MEM_WRITE(mw_h), .STATE(st_h), .HALTED(hl_h));

    control_unit_fsm #(.ILLEGAL_HALT(1'b0)) dut_n (
        .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
        .CTRL(ctrl_n), .MEM_READ(mr_n), .MEM_WRITE(mw_n), .STATE(st_n), .HALTED(hl_n));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    localparam logic [5:0] R_FN [10] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02, 6'h08};
    localparam logic [5:0] I_OP [14] = '{6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h02, 6'h03, 6'h1b, 6'h1c};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction set reference: mnemonic from the encoding.
    function automatic string mnem(input logic [31:0] w);
        string m;
        m = "bad";
        if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h20: m = "add";  6'h22: m = "sub";  6'h2c: m = "mul";
                6'h24: m = "and";  6'h25: m = "or";   6'h27: m = "nor";
                6'h2a: m = "slt";  6'h01: m = "sll";  6'h02: m = "srl";
                6'h08: m = "jr";
                default: m = "bad";
            endcase
        end else begin
            case (w[31:26])
                6'h08: m = "addi"; 6'h1d: m = "muli"; 6'h0c: m = "andi";
                6'h0d: m = "ori";  6'h0f: m = "lui";  6'h0a: m = "slti";
                6'h04: m = "beq";  6'h05: m = "bne";  6'h23: m = "lw";
                6'h2b: m = "sw";   6'h02: m = "jmp";  6'h03: m = "jal";
                6'h1b: m = "push"; 6'h1c: m = "pop";
                default: m = "bad";
            endcase
        end
        return m;
    endfunction

    // Expected outputs for a phase (0..4 = FETCH..WB, 5 = HALT) of an instruction.
    function automatic void model_out(input int ph, input logic [31:0] ir, input logic z,
                                      output logic [31:0] c, output logic mr, output logic mw);
        string k, dest, wsrc;
        int alu;
        k = mnem(ir);
        c = '0; mr = 1'b0; mw = 1'b0;
        case (ph)
            0: begin c[31] = 1'b1; c[30] = 1'b1; c[4] = 1'b1; mr = 1'b1; end
            1: begin c[7] = 1'b1; c[6] = (k != "push"); end
            2: begin
                case (k)
                    "add", "addi", "lw", "sw", "pop":  alu = 1;
                    "sub", "beq", "bne", "push":       alu = 2;
                    "mul", "muli":                     alu = 3;
                    "srl":                             alu = 4;
                    "sll":                             alu = 5;
                    "and", "andi":                     alu = 6;
                    "or", "ori":                       alu = 7;
                    "nor":                             alu = 8;
                    "slt", "slti":                     alu = 9;
                    default:                           alu = 0;
                endcase
                c[25:21] = alu[4:0];
                case (k)
                    "add", "sub", "mul", "and", "or", "nor", "slt", "beq", "bne": c[20] = 1'b1;
                    "sll", "srl":  begin c[19] = 1'b1; c[17] = 1'b1; end
                    "addi", "muli", "slti", "lw", "sw": c[18] = 1'b1;
                    "push", "pop": begin c[16] = 1'b1; c[19] = 1'b1; end
                    default: ;
                endcase
            end
            3: begin
                case (k)
                    "lw":   begin c[27] = 1'b1; mr = 1'b1; end
                    "pop":  begin c[27] = 1'b1; c[26] = 1'b1; mr = 1'b1; end
                    "sw":   begin c[28] = 1'b1; mw = 1'b1; end
                    "push": begin c[28] = 1'b1; c[26] = 1'b1; c[29] = 1'b1; mw = 1'b1; end
                    default: ;
                endcase
            end
            4: begin
                c[0] = 1'b1;
                c[1] = (k != "jr");
                c[3] = !(k == "jmp" || k == "jal");
                c[2] = (k == "beq") ? z : (k == "bne") ? !z : 1'b0;
                case (k)
                    "add", "sub", "mul", "and", "or", "nor", "slt", "sll", "srl": dest = "rd";
                    "addi", "muli", "andi", "ori", "slti", "lw", "lui":          dest = "rt";
                    "pop": dest = "r0";
                    "jal": dest = "r31";
                    default: dest = "";
                endcase
                case (k)
                    "lw", "pop": wsrc = "mem";
                    "lui":       wsrc = "imm";
                    "jal":       wsrc = "pc1";
                    default:     wsrc = "alu";
                endcase
                if (dest != "") begin
                    c[8]  = 1'b1;
                    c[11] = (dest == "rd" || dest == "rt");
                    c[9]  = (dest == "rt");
                    c[10] = (dest == "r31");
                    c[14] = (wsrc != "pc1");
                    c[12] = (wsrc == "mem");
                    c[13] = (wsrc == "imm");
                end
                c[15] = (k == "push" || k == "pop");
            end
            default: ;
        endcase
    endfunction

    // Behavioural sequencing model; index 0 halts on bad encodings, index 1 does not.
    int          m_ph [2];
    logic [31:0] m_ir [2];
    logic        m_z  [2];

    always @(posedge CLK) begin
        for (int v = 0; v < 2; v++) begin
            if (RST) begin
                m_ph[v] <= 0; m_ir[v] <= '0; m_z[v] <= 1'b0;
            end else if (m_ph[v] == 5) begin
                m_ph[v] <= 5;
            end else if (m_ph[v] == 1 && v == 0 && mnem(m_ir[v]) == "bad") begin
                m_ph[v] <= 5;
            end else begin
                if (m_ph[v] == 0) m_ir[v] <= INSTRUCTION;
                if (m_ph[v] == 2) m_z[v] <= ZERO;
                m_ph[v] <= (m_ph[v] + 1) % 5;
            end
        end
    end

    always @(negedge CLK) begin : compare
        logic [31:0] ec;
        logic        emr, emw;
        if (chk_en) begin
            for (int v = 0; v < 2; v++) begin
                model_out(m_ph[v], m_ir[v], m_z[v], ec, emr, emw);
                chk(v == 0 ? "ctrl_halt_dut" : "ctrl_nop_dut", v == 0 ? ctrl_h : ctrl_n, ec);
                chk(v == 0 ? "mem_read_halt_dut" : "mem_read_nop_dut", 32'(v == 0 ? mr_h : mr_n), 32'(emr));
                chk(v == 0 ? "mem_write_halt_dut" : "mem_write_nop_dut", 32'(v == 0 ? mw_h : mw_n), 32'(emw));
                chk(v == 0 ? "state_halt_dut" : "state_nop_dut", 32'(v == 0 ? st_h : st_n), 32'(m_ph[v]));
                chk(v == 0 ? "halted_halt_dut" : "halted_nop_dut", 32'(v == 0 ? hl_h : hl_n), 32'(m_ph[v] == 5));
            end
        end
    end

    logic [31:0] cap_c [5];
    logic [31:0] cap_cn[5];
    logic [2:0]  cap_st[5];
    logic        cap_mw[5];

    // Entered at the negedge of a FETCH cycle; returns at the next FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic z);
        INSTRUCTION = ins;
        ZERO = z;
        for (int p = 0; p < 5; p++) begin
            cap_c[p]  = ctrl_h;
            cap_cn[p] = ctrl_n;
            cap_st[p] = st_h;
            cap_mw[p] = mw_h;
            @(negedge CLK);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w = $urandom;
        sel = $urandom_range(0, 29);
        if (sel < 10) begin
            w[31:26] = 6'h00; w[5:0] = R_FN[sel];
        end else if (sel < 24) begin
            w[31:26] = I_OP[sel - 10];
        end else if (sel < 27) begin
            w[31:26] = 6'h00; w[5:0] = (sel == 24) ? 6'h3F : (sel == 25) ? 6'h00 : 6'h21;
        end else begin
            w[31:26] = (sel == 27) ? 6'h3F : (sel == 28) ? 6'h01 : 6'h3E;
        end
        return w;
    endfunction

    initial begin
        int nmw, nregw;
        chk_en = 1'b1;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("reset_state", 32'(st_h), 32'd0);
        chk("reset_ctrl", ctrl_h, 32'hC0000010);
        chk("reset_mem_read", 32'(mr_h), 32'd1);
        chk("reset_mem_write", 32'(mw_h), 32'd0);
        chk("reset_halted", 32'(hl_h), 32'd0);

        // add $3,$1,$2
        run_instr(32'h00221820, 1'b0);
        for (int p = 0; p < 5; p++) chk("state_sequence", 32'(cap_st[p]), 32'(p));
        chk("state_back_to_fetch", 32'(st_h), 32'd0);
        chk("add_exe_ctrl", cap_c[2], 32'h00300000);
        chk("add_wb_ctrl", cap_c[4], 32'h0000490B);

        // beq taken / not taken
        run_instr(32'h10220003, 1'b1);
        chk("beq_exe_ctrl", cap_c[2], 32'h00500000);
        chk("beq_z1_wb_ctrl", cap_c[4], 32'h0000000F);
        run_instr(32'h10220003, 1'b0);
        chk("beq_z0_wb_ctrl", cap_c[4], 32'h0000000B);

        // sw: single write strobe, never a register write
        run_instr(32'hAC220004, 1'b0);
        nmw = 0; nregw = 0;
        for (int p = 0; p < 5; p++) begin
            nmw += int'(cap_mw[p]);
            nregw += int'(cap_c[p][8]);
        end
        chk("sw_mem_ctrl", cap_c[3], 32'h10000000);
        chk("sw_mem_write_in_mem", 32'(cap_mw[3]), 32'd1);
        chk("sw_mem_write_cycles", 32'(nmw), 32'd1);
        chk("sw_reg_w_cycles", 32'(nregw), 32'd0);

        // jal
        run_instr(32'h0C000010, 1'b0);
        chk("jal_wb_ctrl", cap_c[4], 32'h00000503);

        // illegal opcode: halt variant parks, nop variant only advances PC
        run_instr(32'hFC000000, 1'b0);
        chk("illegal_state", 32'(cap_st[2]), 32'd5);
        chk("illegal_halt_ctrl", cap_c[2], 32'h0);
        chk("illegal_nop_exe_ctrl", cap_cn[2], 32'h0);
        chk("illegal_nop_wb_ctrl", cap_cn[4], 32'h0000000B);
        chk("halt_sticky_state", 32'(st_h), 32'd5);
        chk("halt_sticky_halted", 32'(hl_h), 32'd1);
        chk("halt_sticky_ctrl", ctrl_h, 32'h0);

        // reset, then reset again during EXE of the next instruction
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("halt_exit_state", 32'(st_h), 32'd0);
        INSTRUCTION = 32'h00221820;
        @(negedge CLK);
        @(negedge CLK);
        chk("before_abort_state", 32'(st_h), 32'd2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_state", 32'(st_h), 32'd0);
        chk("abort_ctrl", ctrl_h, 32'hC0000010);
        chk("abort_state_nop_dut", 32'(st_n), 32'd0);
        run_instr(32'h0C000010, 1'b0);
        chk("after_abort_jal_wb", cap_c[4], 32'h00000503);

        // randomized traffic; INSTRUCTION/ZERO change every cycle
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 59) == 0);
            INSTRUCTION = rand_instr();
            ZERO = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
